ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: latches the EX result, issues one memory request per
// load/store, aligns load data, and hands the result to WB with forwarding to ID.
module ex_mem_stage (
  input  logic        clk,
  input  logic        resetn,
  // EX -> MEM handshake and payload
  input  logic        es_to_ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_alu_result,
  input  logic [31:0] es_rt_value,
  input  logic [4:0]  es_dest,
  input  logic        es_mem_re,
  input  logic        es_mem_we,
  input  logic [1:0]  es_mem_size,
  input  logic        es_load_sign,
  input  logic [31:0] es_pc,
  // data memory port
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  // pipeline control
  input  logic        flush,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic [69:0] ms_to_ws_bus,
  // forwarding to ID
  output logic [4:0]  ms_fwd_dest,
  output logic [31:0] ms_fwd_data,
  output logic        ms_fwd_block,
  // FSM state for debug and checkers
  output logic [2:0]  o_dbg_state
);

  // Handshake: a transfer on either side happens on a rising edge where the
  // producer's valid and the consumer's allowin are both high in the preceding
  // cycle; a producer never withdraws valid until it transfers or is flushed.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_ms_valid;
  logic [31:0] r_pc;
  logic [4:0]  r_dest;
  logic [31:0] r_addr;
  logic [31:0] r_rt;
  logic        r_re;
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sign;
  logic        r_ale;
  logic [31:0] r_result;

  logic        w_ready_go;
  logic        w_accept;
  logic        w_capture;
  logic        w_in_mem;
  logic        w_in_misalign;
  logic        w_in_ale;
  logic        w_in_issue;
  state_t      w_accept_state;
  logic [31:0] w_shifted;
  logic [31:0] w_load_value;
  logic [3:0]  w_strb_mask;

  // Decode of the instruction being offered by EX
  assign w_in_mem      = es_mem_re | es_mem_we;
  assign w_in_misalign = ((es_mem_size == 2'd1) & es_alu_result[0]) |
                         (es_mem_size[1] & (es_alu_result[1:0] != 2'b00));
  assign w_in_ale      = w_in_mem & w_in_misalign;
  assign w_in_issue    = w_in_mem & ~w_in_misalign;
  assign w_accept_state = w_in_issue ? S_REQ : S_DONE;

  assign w_ready_go = (r_state == S_DONE);
  assign ms_allowin = (r_state != S_DRAIN) &
                      (~r_ms_valid | (w_ready_go & ws_allowin));
  // flush wins over a same-cycle acceptance
  assign w_accept   = es_to_ms_valid & ms_allowin & ~flush;

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    if (flush) begin
      if ((r_state == S_WAIT || r_state == S_DRAIN) && !data_data_ok) begin
        w_next_state = S_DRAIN;
      end else begin
        w_next_state = S_IDLE;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) w_next_state = w_accept_state;
        end
        S_REQ: begin
          if (data_addr_ok) begin
            if (data_data_ok) begin
              w_next_state = S_DONE;
              w_capture    = 1'b1;
            end else begin
              w_next_state = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (data_data_ok) begin
            w_next_state = S_DONE;
            w_capture    = 1'b1;
          end
        end
        S_DONE: begin
          if (ws_allowin) w_next_state = w_accept ? w_accept_state : S_IDLE;
        end
        S_DRAIN: begin
          if (data_data_ok) w_next_state = S_IDLE;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ms_valid <= 1'b0;
    end else if (flush) begin
      r_ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      r_ms_valid <= es_to_ms_valid;
    end
  end

  // Misaligned accesses keep the faulting address as their result
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_pc     <= 32'd0;
      r_dest   <= 5'd0;
      r_addr   <= 32'd0;
      r_rt     <= 32'd0;
      r_re     <= 1'b0;
      r_we     <= 1'b0;
      r_size   <= 2'd0;
      r_sign   <= 1'b0;
      r_ale    <= 1'b0;
      r_result <= 32'd0;
    end else if (w_accept) begin
      r_pc     <= es_pc;
      r_dest   <= w_in_ale ? 5'd0 : es_dest;
      r_addr   <= es_alu_result;
      r_rt     <= es_rt_value;
      r_re     <= es_mem_re;
      r_we     <= es_mem_we;
      r_size   <= es_mem_size;
      r_sign   <= es_load_sign;
      r_ale    <= w_in_ale;
      r_result <= w_in_issue ? 32'd0 : es_alu_result;
    end else if (w_capture && r_re) begin
      r_result <= w_load_value;
    end
  end

  assign w_shifted = data_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_value = w_shifted;
    case (r_size)
      2'd0:    w_load_value = {{24{r_sign & w_shifted[7]}},  w_shifted[7:0]};
      2'd1:    w_load_value = {{16{r_sign & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load_value = w_shifted;
    endcase
  end

  always_comb begin
    w_strb_mask = 4'b1111;
    data_wdata  = r_rt;
    case (r_size)
      2'd0: begin
        w_strb_mask = 4'b0001 << r_addr[1:0];
        data_wdata  = {4{r_rt[7:0]}};
      end
      2'd1: begin
        w_strb_mask = 4'b0011 << r_addr[1:0];
        data_wdata  = {2{r_rt[15:0]}};
      end
      default: begin
        w_strb_mask = 4'b1111;
        data_wdata  = r_rt;
      end
    endcase
  end

  // A flush in REQ pulls the request back in the same cycle
  assign data_req   = (r_state == S_REQ) & ~flush;
  assign data_wr    = r_we;
  assign data_wstrb = r_we ? w_strb_mask : 4'b0000;
  assign data_addr  = {r_addr[31:2], 2'b00};

  assign ms_to_ws_valid = r_ms_valid & w_ready_go;
  assign ms_to_ws_bus   = {r_pc, r_dest, r_result, r_ale};

  assign ms_fwd_dest  = r_ms_valid ? r_dest : 5'd0;
  assign ms_fwd_data  = r_result;
  assign ms_fwd_block = r_ms_valid & r_re & (r_state != S_DONE);

  assign o_dbg_state = r_state;

endmodule
